alu_op_arbiter: RTL and testbench

Two-requester front end for the 32-bit ALU datapath (`ALU_design`). It accepts operation requests over valid/ready handshakes and arbitrates between them round-robin. It drives the ALU operand and control inputs as stable registers for the whole operation, then waits the ALU's fixed pipeline latency. It returns the captured result, flags and requester id on a single response channel. Only one operation is outstanding at a time. Opcodes the ALU does not define are rejected without being issued.

---
 rtl/alu_op_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_op_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_arbiter.sv
// ---------------------------------------------------------------------------
// alu_op_arbiter
//
// Two-requester front end for the 32-bit ALU datapath. Requests arrive on
// valid/ready handshakes. When both requesters are valid, they are served
// round-robin. At most one operation is outstanding at a time.
//
// For a legal opcode, the operands and control are registered onto the ALU
// inputs and held constant. The block then waits for the ALU pipeline latency
// and captures the result onto a single response channel. Opcodes the ALU does
// not define, and divide by zero, are answered at once with rsp_err=1 and are
// never issued to the ALU.
//
// Parameters
//   LAT_ARITH  ALU register stages for arithmetic ops (ctrl[4:3]==00)
//   LAT_OTHER  ALU register stages for boolean, compare and shift ops
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid[1:0]              per-requester op present
//   req_ready[1:0]              combinational accept strobe (one-hot or zero)
//   req{0,1}_op/_a/_b           ALU_CONTROL code and operands per requester
//   rsp_valid, rsp_ready        response handshake
//   rsp_id, rsp_y, rsp_flags    requester id, result, {Z,V,N,C}
//   rsp_err                     op rejected without issue
//   alu_a, alu_b, alu_ctrl      registered ALU inputs
//   alu_y, alu_z/v/n/c          ALU result and flags
//   busy                        high whenever not IDLE
// ---------------------------------------------------------------------------
module alu_op_arbiter #(
    parameter int LAT_ARITH = 2,
    parameter int LAT_OTHER = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [4:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_y,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_ctrl,
    input  logic [31:0] alu_y,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_n,
    input  logic        alu_c,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [7:0] CNT_ARITH = 8'(LAT_ARITH);
    localparam logic [7:0] CNT_OTHER = 8'(LAT_OTHER);

    // Opcodes the ALU leaves undefined, plus divide by a zero low divisor field.
    function automatic logic op_invalid(input logic [4:0] op, input logic [31:0] b);
        logic bad;
        case (op)
            5'b01110, 5'b01111, 5'b10011: bad = 1'b1;
            5'b00011:                     bad = (b[14:0] == 15'd0);
            default:                      bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Arithmetic group: the only ops whose flags are meaningful.
    function automatic logic op_is_arith(input logic [4:0] op);
        return (op[4:3] == 2'b00);
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nx_s;
    logic [7:0]  cnt_r;
    logic        last_r;
    logic [1:0]  grant_s;
    logic        accept_s;
    logic        sel_id_s;
    logic [4:0]  sel_op_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic        sel_bad_s;

    logic        rsp_valid_r;
    logic        busy_r;
    logic        rsp_id_r;
    logic [31:0] rsp_y_r;
    logic [3:0]  rsp_flags_r;
    logic        rsp_err_r;
    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic [4:0]  alu_ctrl_r;

    // Round-robin grant, only offered in IDLE; on contention the requester
    // that did not win last time is favoured.
    always_comb begin
        grant_s = 2'b00;
        if (state_r == ST_IDLE) begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign req_ready = grant_s;
    assign accept_s  = grant_s[0] | grant_s[1];
    assign sel_id_s  = grant_s[1];
    assign sel_op_s  = sel_id_s ? req1_op : req0_op;
    assign sel_a_s   = sel_id_s ? req1_a  : req0_a;
    assign sel_b_s   = sel_id_s ? req1_b  : req0_b;
    assign sel_bad_s = op_invalid(sel_op_s, sel_b_s);

    // Next-state decode for the IDLE -> BUSY -> RESP sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = sel_bad_s ? ST_RESP : ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 8'd0) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Control state: FSM, latency counter, last-grant pointer and the
    // registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            last_r      <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            rsp_valid_r <= (state_nx_s == ST_RESP);
            busy_r      <= (state_nx_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        last_r <= sel_id_s;
                        cnt_r  <= op_is_arith(sel_op_s) ? CNT_ARITH : CNT_OTHER;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r != 8'd0) begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: the ALU inputs are loaded only on a legal accept, and the
    // response fields are loaded on reject or when the ALU result is due.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_r    <= 1'b0;
            rsp_y_r     <= 32'd0;
            rsp_flags_r <= 4'd0;
            rsp_err_r   <= 1'b0;
            alu_a_r     <= 32'd0;
            alu_b_r     <= 32'd0;
            alu_ctrl_r  <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        rsp_id_r <= sel_id_s;
                        if (sel_bad_s) begin
                            rsp_err_r   <= 1'b1;
                            rsp_y_r     <= 32'd0;
                            rsp_flags_r <= 4'd0;
                        end else begin
                            alu_a_r    <= sel_a_s;
                            alu_b_r    <= sel_b_s;
                            alu_ctrl_r <= sel_op_s;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == 8'd0) begin
                        rsp_y_r     <= alu_y;
                        rsp_err_r   <= 1'b0;
                        rsp_flags_r <= op_is_arith(alu_ctrl_r) ?
                                       {alu_z, alu_v, alu_n, alu_c} : 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign busy      = busy_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_y     = rsp_y_r;
    assign rsp_flags = rsp_flags_r;
    assign rsp_err   = rsp_err_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_ctrl  = alu_ctrl_r;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_op_arbiter
//
// Directed bench for alu_op_arbiter. A small combinational ALU stand-in
// drives alu_y and the flags. The stand-in raises Z/N for every op, so any
// flags leaking through on non-arithmetic ops become visible. All expected
// values below are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_op_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [4:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_y;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_y;
    logic        alu_z;
    logic        alu_v;
    logic        alu_n;
    logic        alu_c;
    logic        busy;

    int n_chk;
    int n_pass;

    alu_op_arbiter #(.LAT_ARITH(2), .LAT_OTHER(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_y(alu_y), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n), .alu_c(alu_c),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: ADD, AND, XOR; other codes return 0.
    always_comb begin
        logic [32:0] sum;
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_ctrl)
            5'b00000: begin
                alu_y = sum[31:0];
                alu_c = sum[32];
                alu_v = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            5'b01000: alu_y = alu_a & alu_b;
            5'b01010: alu_y = alu_a ^ alu_b;
            default:  alu_y = 32'd0;
        endcase
        alu_z = (alu_y == 32'd0);
        alu_n = alu_y[31];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge. Presents one op, checks its grant, and returns the
    // cycle count from the handshake to rsp_valid (1 == T+1).
    task automatic do_op(input logic id, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic chk_alu, output int lat);
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req_valid = 2'b10;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req_valid = 2'b01;
        end
        #1;
        chk("grant", 64'(req_ready), id ? 64'h2 : 64'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        lat = 1;
        if (chk_alu) begin
            chk("alu_a@T+1", 64'(alu_a), 64'(a));
            chk("alu_b@T+1", 64'(alu_b), 64'(b));
            chk("alu_ctrl@T+1", 64'(alu_ctrl), 64'(op));
        end
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_rsp();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int k;
        logic [31:0] y_hold;
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
        req0_op = 5'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_op = 5'd0; req1_a = 32'd0; req1_b = 32'd0;
        @(negedge clk);
        chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst busy", 64'(busy), 64'h0);
        chk("rst alu_a", 64'(alu_a), 64'h0);
        chk("rst rsp_y", 64'(rsp_y), 64'h0);
        do_reset();

        // ADD 5+3, arithmetic latency
        do_op(1'b0, 5'b00000, 32'd5, 32'd3, 1'b1, lat);
        chk("add lat", 64'(lat), 64'd4);
        chk("add busy", 64'(busy), 64'h1);
        chk("add y", 64'(rsp_y), 64'h8);
        chk("add flags", 64'(rsp_flags), 64'h0);
        chk("add id", 64'(rsp_id), 64'h0);
        chk("add err", 64'(rsp_err), 64'h0);
        finish_rsp();
        chk("idle busy", 64'(busy), 64'h0);

        // AND from req1, boolean latency, flags suppressed
        do_op(1'b1, 5'b01000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, lat);
        chk("and lat", 64'(lat), 64'd3);
        chk("and y", 64'(rsp_y), 64'hF000F000);
        chk("and flags", 64'(rsp_flags), 64'h0);
        chk("and id", 64'(rsp_id), 64'h1);
        finish_rsp();

        // ADD wrapping to zero: Z and C set
        do_op(1'b0, 5'b00000, 32'hFFFFFFFF, 32'h1, 1'b0, lat);
        chk("addc y", 64'(rsp_y), 64'h0);
        chk("addc flags", 64'(rsp_flags), 64'h9);
        finish_rsp();

        // Undefined boolean code: rejected, ALU inputs untouched
        do_op(1'b1, 5'b01110, 32'h11111111, 32'h22222222, 1'b0, lat);
        chk("inv lat", 64'(lat), 64'd1);
        chk("inv err", 64'(rsp_err), 64'h1);
        chk("inv y", 64'(rsp_y), 64'h0);
        chk("inv flags", 64'(rsp_flags), 64'h0);
        chk("inv id", 64'(rsp_id), 64'h1);
        chk("inv alu_a", 64'(alu_a), 64'hFFFFFFFF);
        chk("inv alu_ctrl", 64'(alu_ctrl), 64'h0);
        finish_rsp();

        // Divide by zero: rejected
        do_op(1'b0, 5'b00011, 32'h00000064, 32'h00000000, 1'b0, lat);
        chk("div0 lat", 64'(lat), 64'd1);
        chk("div0 err", 64'(rsp_err), 64'h1);
        chk("div0 alu_b", 64'(alu_b), 64'h1);
        finish_rsp();

        // Backpressure: response held while req1 waits
        rsp_ready = 1'b0;
        do_op(1'b0, 5'b01010, 32'h12345678, 32'h0F0F0F0F, 1'b0, lat);
        chk("xor lat", 64'(lat), 64'd3);
        chk("xor err", 64'(rsp_err), 64'h0);
        y_hold = rsp_y;
        chk("bp y", 64'(y_hold), 64'h1D3B5977);
        req1_op = 5'b01010; req1_a = 32'hAAAA0000; req1_b = 32'h00005555;
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp valid", 64'(rsp_valid), 64'h1);
            chk("bp ready", 64'(req_ready), 64'h0);
            chk("bp y hold", 64'(rsp_y), 64'h1D3B5977);
            chk("bp id hold", 64'(rsp_id), 64'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp next grant", 64'(req_ready), 64'h2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bp2 lat", 64'(k), 64'd3);
        chk("bp2 y", 64'(rsp_y), 64'hAAAA5555);
        chk("bp2 id", 64'(rsp_id), 64'h1);
        finish_rsp();

        // Round-robin from reset, both requesters always valid
        do_reset();
        req0_op = 5'b01010; req0_a = 32'h12345678; req0_b = 32'h0F0F0F0F;
        req1_op = 5'b01010; req1_a = 32'hAAAA0000; req1_b = 32'h00005555;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            #1;
            while (req_ready == 2'b00 && k < 10) begin
                @(negedge clk);
                #1;
                k++;
            end
            chk("rr grant", 64'(req_ready), (g % 2 == 1) ? 64'h2 : 64'h1);
            @(posedge clk);
            @(negedge clk);
            k = 1;
            while (!rsp_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("rr id", 64'(rsp_id), 64'(g % 2));
            chk("rr y", 64'(rsp_y), (g % 2 == 1) ? 64'hAAAA5555 : 64'h1D3B5977);
            finish_rsp();
        end
        req_valid = 2'b00;

        // Reset in the second BUSY cycle of an ADD
        @(negedge clk);
        req0_op = 5'b00000; req0_a = 32'd7; req0_b = 32'd9; req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("mid busy pre", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid busy", 64'(busy), 64'h0);
        chk("mid alu_a", 64'(alu_a), 64'h0);
        chk("mid alu_b", 64'(alu_b), 64'h0);
        chk("mid rsp_y", 64'(rsp_y), 64'h0);
        chk("mid rsp_valid", 64'(rsp_valid), 64'h0);
        chk("mid rsp_id", 64'(rsp_id), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("post-rst grant", 64'(req_ready), 64'h1);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
